// File: rtl/sub_serial_8bits_pkg.sv
// rtl/sub_serial_8bits_pkg.sv - shared width and FSM encodings for the serial subtractor
package sub_serial_8bits_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_serial_8bits_fullsubtractor.sv
// rtl/sub_serial_8bits_fullsubtractor.sv - one-bit combinational full subtractor
module fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/sub_serial_8bits.sv
// rtl/sub_serial_8bits.sv - bit-serial 8-bit subtractor, LSB first, start/done handshake
module sub_serial_8bits
  import sub_serial_8bits_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  state_t state, state_next;

  logic [WIDTH-1:0] ra, rb;
  // Holds the first seven result bits; the eighth goes straight into D.
  logic [WIDTH-2:0] rd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic load, step, last;
  logic d_bit, b_bit;

  fullsubtractor u_fs (
    .A    (ra[0]),
    .B    (rb[0]),
    .Bin  (br),
    .D    (d_bit),
    .Bout (b_bit)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state == ST_SUB);
  assign done = (state == ST_DONE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SUB;
        end
      end
      ST_SUB: begin
        step = 1'b1;
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SUB;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        ra  <= A;
        rb  <= B;
        br  <= Bin;
        cnt <= '0;
      end else if (step) begin
        ra  <= {1'b0, ra[WIDTH-1:1]};
        rb  <= {1'b0, rb[WIDTH-1:1]};
        rd  <= {d_bit, rd[WIDTH-2:1]};
        br  <= b_bit;
        cnt <= cnt + CNT_W'(1);
        // Results only become visible as the final bit completes.
        if (last) begin
          D    <= {d_bit, rd};
          Bout <= b_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_serial_8bits.sv
// tb/tb_sub_serial_8bits.sv - directed self-checking bench for sub_serial_8bits
module tb_sub_serial_8bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       Bin;
  logic [7:0] D;
  logic       Bout, busy, done;

  int checks = 0;
  int errors = 0;

  sub_serial_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Issues one operation and observes it; operands are scrambled right after sampling.
  task automatic do_sub(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic hold, output int nbusy, output int done_at,
                        output logic [7:0] d, output logic bo);
    nbusy   = 0;
    done_at = 0;
    d       = 8'h00;
    bo      = 1'b0;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        A = 8'hC3; B = 8'h99; Bin = ~bin;
        if (!hold) start = 1'b0;
      end
      if (busy) nbusy++;
      if (done) begin
        done_at = i; d = D; bo = Bout; start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL reset_D got %h want 00", D); end
    checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL reset_Bout got %b want 0", Bout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int nb, da; logic [7:0] d; logic bo;
    do_sub(8'h5A, 8'h3C, 1'b0, 1'b0, nb, da, d, bo);
    checks++; if (nb !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", nb); end
    checks++; if (da !== 9) begin errors++; $display("FAIL basic_done_cycle got %0d want 9", da); end
    checks++; if (d !== 8'h1E) begin errors++; $display("FAIL basic_D got %h want 1e", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_Bout got %b want 0", bo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (D !== 8'h1E) begin errors++; $display("FAIL basic_D_hold got %h want 1e", D); end
  endtask

  task automatic test_underflow();
    int nb, da; logic [7:0] d; logic bo;
    do_sub(8'h00, 8'h01, 1'b0, 1'b0, nb, da, d, bo);
    checks++; if (da !== 9) begin errors++; $display("FAIL under_done_cycle got %0d want 9", da); end
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL under_D got %h want ff", d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL under_Bout got %b want 1", bo); end
  endtask

  task automatic test_borrow_in();
    int nb, da; logic [7:0] d; logic bo;
    do_sub(8'h80, 8'h7F, 1'b1, 1'b0, nb, da, d, bo);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bin1_D got %h want 00", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL bin1_Bout got %b want 0", bo); end
    do_sub(8'hFF, 8'hFF, 1'b1, 1'b0, nb, da, d, bo);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL bin2_D got %h want ff", d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL bin2_Bout got %b want 1", bo); end
  endtask

  task automatic test_start_held();
    int nb, da; logic [7:0] d; logic bo;
    do_sub(8'h3C, 8'h5A, 1'b0, 1'b1, nb, da, d, bo);
    checks++; if (nb !== 8) begin errors++; $display("FAIL held_busy_cycles got %0d want 8", nb); end
    checks++; if (da !== 9) begin errors++; $display("FAIL held_done_cycle got %0d want 9", da); end
    checks++; if (d !== 8'hE2) begin errors++; $display("FAIL held_D got %h want e2", d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL held_Bout got %b want 1", bo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int nb, da, gap; logic [7:0] d; logic bo;
    do_sub(8'h5A, 8'h3C, 1'b0, 1'b0, nb, da, d, bo);
    // still in the DONE cycle: request the next operation now
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    gap = 0;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 4) begin
        checks++; if (D !== 8'h1E) begin errors++; $display("FAIL b2b_D_midop got %h want 1e", D); end
      end
      if (done) begin gap = i; break; end
    end
    checks++; if (gap !== 9) begin errors++; $display("FAIL b2b_done_gap got %0d want 9", gap); end
    checks++; if (D !== 8'h0F) begin errors++; $display("FAIL b2b_D got %h want 0f", D); end
    checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL b2b_Bout got %b want 0", Bout); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    A = 8'h5A; B = 8'h3C; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL rmid_D got %h want 00", D); end
    checks++; if (Bout !== 1'b0) begin errors++; $display("FAIL rmid_Bout got %b want 0", Bout); end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", seen_done); end
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL rmid_D_after got %h want 00", D); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_in();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
